// File: rtl/serial_adder_64.sv
// Digit-serial adder: sum = a + b + cin over WIDTH/DIGIT cycles, one DIGIT-bit slice per cycle.
// Define SERIAL_ADDER_CC_EN to add the zf/sf/of condition-code outputs.
module serial_adder_64 #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_CC_EN
  ,
  output logic             zf,
  output logic             sf,
  output logic             of
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_cfg_err
    $fatal(1, "serial_adder_64: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, work_q, work_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
`ifdef SERIAL_ADDER_CC_EN
  logic               zf_q, zf_d, sf_q, sf_d, of_q, of_d;
`endif

  logic [DIGIT-1:0]   a_dig, b_dig, dig_sum;
  logic               dig_cout;
  logic               last;

  // One carry-chain slice shared by every digit position.
  always_comb begin
    a_dig               = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig               = b_q[cnt_q*DIGIT +: DIGIT];
    {dig_cout, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    last                = (cnt_q == CNT_W'(N - 1));
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef SERIAL_ADDER_CC_EN
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        work_d[cnt_q*DIGIT +: DIGIT] = dig_sum;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d       = work_d;
          cout_d      = dig_cout;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
`ifdef SERIAL_ADDER_CC_EN
          zf_d = (work_d == '0);
          sf_d = dig_sum[DIGIT-1];
          // Carry into the MSB recovered from the MSB's own sum bit.
          of_d = (a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1]) ^ dig_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SERIAL_ADDER_CC_EN
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SERIAL_ADDER_CC_EN
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
`endif
    end
  end

  // NOTE: operand and working registers are deliberately not reset; each is fully written before it is read.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    work_q <= work_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_CC_EN
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
`endif

endmodule

// File: tb/tb_serial_adder_64.sv
// Directed bench for serial_adder_64 with a result scoreboard.
// Flag checks are enabled when SERIAL_ADDER_CC_EN is defined.
module tb_serial_adder_64;

  localparam int W   = 64;
  localparam int LAT = 16;

  logic         clk, rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_CC_EN
  logic         zf, sf, of;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         zf;
    logic         sf;
    logic         of;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_adder_64 #(.WIDTH(W), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_CC_EN
    ,
    .zf        (zf),
    .sf        (sf),
    .of        (of)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.zf   = (e.sum == '0);
    e.sf   = e.sum[W-1];
    e.of   = (ta[W-1] == tb[W-1]) && (e.sum[W-1] != ta[W-1]);
    return e;
  endfunction

  // Drive one operand set from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 64'd0, 64'd1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    if (push) sb.push_back(model(ta, tb, tc));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, check latency and compare against the scoreboard head.
  task automatic get_result(input string tag, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_lat > 0) check({tag, "_latency"}, W'(cyc), W'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},  sum,       e.sum);
      check({tag, "_cout"}, W'(cout),  W'(e.cout));
`ifdef SERIAL_ADDER_CC_EN
      check({tag, "_zf"},   W'(zf),    W'(e.zf));
      check({tag, "_sf"},   W'(sf),    W'(e.sf));
      check({tag, "_of"},   W'(of),    W'(e.of));
`endif
    end
  endtask

  task automatic hand(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_after_hs"},  W'(in_ready),  64'd1);
    check({tag, "_out_valid_after_hs"}, W'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t bp;
    bit   seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sum",       sum,            64'd0);
    check("rst_cout",      W'(cout),       64'd0);
    check("rst_out_valid", W'(out_valid),  64'd0);
    check("rst_in_ready",  W'(in_ready),   64'd1);
`ifdef SERIAL_ADDER_CC_EN
    check("rst_flags",     W'({zf, sf, of}), 64'd0);
`endif

    // Basic add
    out_ready = 1'b1;
    send(64'h5, 64'h3, 1'b0, 1'b1);
    get_result("basic", LAT);
    hand("basic");
    check("basic_sum_held_idle", sum, 64'h8);

    // Full carry propagation
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
    get_result("carry", LAT);
    hand("carry");

    // Signed overflow
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    get_result("ovf", LAT);
    hand("ovf");

    // Mixed operands with cin
    send(64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
    get_result("mixed", LAT);
    hand("mixed");

    // Backpressure and operand stability
    out_ready = 1'b0;
    bp = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = ~cin;
      in_valid = ~in_valid;
      check("bp_busy_in_ready", W'(in_ready), 64'd0);
      @(negedge clk);
    end
    get_result("bp", LAT - 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom};
      in_valid = ~in_valid;
      check("bp_done_sum_stable",  sum,           bp.sum);
      check("bp_done_in_ready",    W'(in_ready),  64'd0);
      check("bp_done_out_valid",   W'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    hand("bp");
    check("bp_sum_held_idle", sum, bp.sum);

    // Reset mid-operation: aborted op must never present a result
    send(64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready",  W'(in_ready),  64'd1);
    check("abort_sum_clear", sum,           64'd0);
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", W'(seen), 64'd0);
    send(64'h2, 64'h2, 1'b0, 1'b1);
    get_result("post_abort", LAT);
    hand("post_abort");

    check("sb_drained", W'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
